// File: rtl/polar_pkg.sv
// Shared constants and state encoding for the polar decoder output path.
package polar_pkg;

  localparam int unsigned DEC_MEM_WIDTH = 140;
  localparam int unsigned DEC_MEM_ADDRW = 6;
  localparam int unsigned KW            = 8;
  localparam int unsigned PKT_CNT_W     = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_PKT,
    ST_COLLECT,
    ST_FLUSH,
    ST_DONE
  } dec_wr_state_t;

endpackage

// File: rtl/polar_dec_writer.sv
// Packs the information bits of each decoded packet into one DEC memory word
// and tracks job completion. The memory write enable is tied high, so waddr
// and wdata are always-valid registers.
module polar_dec_writer #(
  parameter int unsigned DEC_MEM_WIDTH = polar_pkg::DEC_MEM_WIDTH,
  parameter int unsigned DEC_MEM_ADDRW = polar_pkg::DEC_MEM_ADDRW,
  parameter int unsigned KW            = polar_pkg::KW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     module_en,
  input  logic [5:0]               i_num_pkt,
  input  logic                     i_pkt_start,
  input  logic [KW-1:0]            i_k,
  input  logic                     i_bit_valid,
  input  logic                     i_bit,
  input  logic                     i_frozen,
  input  logic                     i_pkt_end,
  output logic [DEC_MEM_ADDRW-1:0] waddr,
  output logic [DEC_MEM_WIDTH-1:0] wdata,
  output logic                     o_pkt_done,
  output logic                     proc_done,
  output logic                     o_err
);
  import polar_pkg::*;

  dec_wr_state_t          state;
  logic [PKT_CNT_W-1:0]   num_pkt;
  logic [PKT_CNT_W-1:0]   pkt_cnt;
  logic [KW-1:0]          k;
  logic [KW-1:0]          info_cnt;

  logic                   take;
  logic                   fits;
  logic [KW-1:0]          cnt_next;
  logic [DEC_MEM_WIDTH-1:0] bit_sel;
  logic [KW-1:0]          k_in;
  logic                   k_over;

  // Decode of the current bit slot and clamping of the incoming K.
  always_comb begin
    take     = i_bit_valid && !i_frozen;
    fits     = info_cnt < k;
    cnt_next = (take && fits) ? info_cnt + KW'(1) : info_cnt;
    bit_sel  = '0;
    for (int unsigned j = 0; j < DEC_MEM_WIDTH; j++) begin
      bit_sel[j] = take && fits && (info_cnt == KW'(j));
    end
    k_over = i_k > KW'(DEC_MEM_WIDTH);
    k_in   = k_over ? KW'(DEC_MEM_WIDTH) : i_k;
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      num_pkt    <= '0;
      pkt_cnt    <= '0;
      k          <= '0;
      info_cnt   <= '0;
      waddr      <= '0;
      wdata      <= '0;
      o_pkt_done <= 1'b0;
      proc_done  <= 1'b0;
      o_err      <= 1'b0;
    end else begin
      o_pkt_done <= 1'b0;
      if (!module_en) begin
        // Abort keeps waddr/wdata so the memory keeps rewriting the same row.
        state     <= ST_IDLE;
        proc_done <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            num_pkt   <= i_num_pkt;
            pkt_cnt   <= '0;
            o_err     <= 1'b0;
            proc_done <= 1'b0;
            state     <= (i_num_pkt == '0) ? ST_DONE : ST_WAIT_PKT;
          end
          ST_WAIT_PKT: begin
            if (i_pkt_start) begin
              waddr    <= DEC_MEM_ADDRW'(pkt_cnt);
              wdata    <= '0;
              info_cnt <= '0;
              k        <= k_in;
              if (k_over) o_err <= 1'b1;
              state    <= ST_COLLECT;
            end
          end
          ST_COLLECT: begin
            if (i_pkt_start) begin
              // Restart of the same row: pkt_cnt (and so waddr) is left alone.
              wdata    <= '0;
              info_cnt <= '0;
              k        <= k_in;
              o_err    <= 1'b1;
            end else begin
              wdata    <= (wdata & ~bit_sel) | (bit_sel & {DEC_MEM_WIDTH{i_bit}});
              info_cnt <= cnt_next;
              if (take && !fits) o_err <= 1'b1;
              if (i_pkt_end) begin
                if (cnt_next != k) o_err <= 1'b1;
                if (pkt_cnt != '1) pkt_cnt <= pkt_cnt + 1'b1;
                o_pkt_done <= 1'b1;
                state      <= ST_FLUSH;
              end
            end
          end
          ST_FLUSH: begin
            // Raising proc_done on the way out keeps it at pkt_end + 2.
            if (pkt_cnt == num_pkt) begin
              state     <= ST_DONE;
              proc_done <= 1'b1;
            end else begin
              state <= ST_WAIT_PKT;
            end
          end
          ST_DONE: begin
            proc_done <= 1'b1;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_polar_dec_writer.sv
// Directed bench for polar_dec_writer with a model of the always-write memory.
module tb_polar_dec_writer;
  import polar_pkg::*;

  localparam int unsigned W  = DEC_MEM_WIDTH;
  localparam int unsigned AW = DEC_MEM_ADDRW;

  logic          clk = 1'b0;
  logic          rst;
  logic          module_en;
  logic [5:0]    i_num_pkt;
  logic          i_pkt_start;
  logic [KW-1:0] i_k;
  logic          i_bit_valid;
  logic          i_bit;
  logic          i_frozen;
  logic          i_pkt_end;
  logic [AW-1:0] waddr;
  logic [W-1:0]  wdata;
  logic          o_pkt_done;
  logic          proc_done;
  logic          o_err;

  int tests = 0;
  int fails = 0;
  int pulse_cnt = 0;

  logic [W-1:0] mem [0:(1<<AW)-1];
  logic [W-1:0] ones;

  polar_dec_writer #(
    .DEC_MEM_WIDTH(W),
    .DEC_MEM_ADDRW(AW),
    .KW(KW)
  ) dut (
    .clk(clk), .rst(rst), .module_en(module_en), .i_num_pkt(i_num_pkt),
    .i_pkt_start(i_pkt_start), .i_k(i_k), .i_bit_valid(i_bit_valid),
    .i_bit(i_bit), .i_frozen(i_frozen), .i_pkt_end(i_pkt_end),
    .waddr(waddr), .wdata(wdata), .o_pkt_done(o_pkt_done),
    .proc_done(proc_done), .o_err(o_err)
  );

  always #5 clk = ~clk;

  // Write enable is tied high in the system: every edge stores wdata.
  always @(posedge clk) mem[waddr] <= wdata;

  always @(negedge clk) if (o_pkt_done === 1'b1) pulse_cnt = pulse_cnt + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; module_en = 1'b0; i_num_pkt = '0; i_pkt_start = 1'b0;
    i_k = '0; i_bit_valid = 1'b0; i_bit = 1'b0; i_frozen = 1'b0; i_pkt_end = 1'b0;
    tick(); tick();
    rst = 1'b0;
    pulse_cnt = 0;
  endtask

  task automatic start_job(input logic [5:0] n);
    module_en = 1'b1; i_num_pkt = n;
    tick();
  endtask

  task automatic pkt_start(input logic [KW-1:0] k);
    i_pkt_start = 1'b1; i_k = k;
    tick();
    i_pkt_start = 1'b0;
  endtask

  task automatic put_bit(input logic b, input logic fr, input logic last);
    i_bit_valid = 1'b1; i_bit = b; i_frozen = fr; i_pkt_end = last;
    tick();
    i_bit_valid = 1'b0; i_bit = 1'b0; i_frozen = 1'b0; i_pkt_end = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; module_en = 1'b1; i_num_pkt = 6'd3; i_pkt_start = 1'b1; i_k = 8'd8;
    i_bit_valid = 1'b1; i_bit = 1'b1; i_frozen = 1'b0; i_pkt_end = 1'b1;
    tick(); tick();
    tests++; if (waddr !== '0) begin fails++; $display("FAIL reset_waddr got %0h exp 0", waddr); end
    tests++; if (wdata !== '0) begin fails++; $display("FAIL reset_wdata got %0h exp 0", wdata); end
    tests++; if ({o_pkt_done, proc_done, o_err} !== 3'b000) begin
      fails++; $display("FAIL reset_flags got %b exp 000", {o_pkt_done, proc_done, o_err});
    end
  endtask

  task automatic test_basic();
    logic [7:0] info;
    info = 8'h4D;
    do_reset();
    start_job(6'd1);
    pkt_start(8'd8);
    for (int i = 0; i < 8; i++) put_bit(1'b0, 1'b1, 1'b0);
    for (int j = 0; j < 8; j++) put_bit(info[j], 1'b0, j == 7);
    tests++; if (o_pkt_done !== 1'b1) begin fails++; $display("FAIL basic_pkt_done got %b exp 1", o_pkt_done); end
    tests++; if (wdata !== 'h4D) begin fails++; $display("FAIL basic_wdata got %0h exp 4d", wdata); end
    tests++; if (waddr !== '0) begin fails++; $display("FAIL basic_waddr got %0h exp 0", waddr); end
    tests++; if (proc_done !== 1'b0) begin fails++; $display("FAIL basic_proc_early got %b exp 0", proc_done); end
    tick();
    tests++; if (proc_done !== 1'b1) begin fails++; $display("FAIL basic_proc_done got %b exp 1", proc_done); end
    tests++; if (o_pkt_done !== 1'b0) begin fails++; $display("FAIL basic_pulse_width got %b exp 0", o_pkt_done); end
    tests++; if (o_err !== 1'b0) begin fails++; $display("FAIL basic_err got %b exp 0", o_err); end
    module_en = 1'b0;
    tick();
    tests++; if (proc_done !== 1'b0) begin fails++; $display("FAIL basic_proc_drop got %b exp 0", proc_done); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    start_job(6'd17);
    for (int p = 0; p < 17; p++) begin
      pkt_start(8'd140);
      for (int b = 0; b < 140; b++) put_bit(1'b1, 1'b0, b == 139);
      tests++; if (waddr !== AW'(p)) begin fails++; $display("FAIL b2b_waddr%0d got %0d exp %0d", p, waddr, p); end
      if (p == 15) begin
        tests++; if (proc_done !== 1'b0) begin fails++; $display("FAIL b2b_proc_early got %b exp 0", proc_done); end
      end
      tick();
    end
    tests++; if (proc_done !== 1'b1) begin fails++; $display("FAIL b2b_proc_done got %b exp 1", proc_done); end
    tests++; if (pulse_cnt !== 17) begin fails++; $display("FAIL b2b_pulses got %0d exp 17", pulse_cnt); end
    tests++; if (o_err !== 1'b0) begin fails++; $display("FAIL b2b_err got %b exp 0", o_err); end
    tick();
    for (int r = 0; r < 17; r++) begin
      tests++; if (mem[r] !== ones) begin fails++; $display("FAIL b2b_row%0d got %0h exp all ones", r, mem[r]); end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    start_job(6'd1);
    pkt_start(8'd4);
    for (int b = 0; b < 6; b++) put_bit(1'b1, 1'b0, b == 5);
    tests++; if (wdata !== 'hF) begin fails++; $display("FAIL ovf_wdata got %0h exp f", wdata); end
    tests++; if (o_err !== 1'b1) begin fails++; $display("FAIL ovf_err got %b exp 1", o_err); end
    tick();
    tests++; if (proc_done !== 1'b1) begin fails++; $display("FAIL ovf_proc_done got %b exp 1", proc_done); end
  endtask

  task automatic test_restart();
    do_reset();
    start_job(6'd1);
    pkt_start(8'd8);
    put_bit(1'b1, 1'b0, 1'b0); put_bit(1'b1, 1'b0, 1'b0); put_bit(1'b1, 1'b0, 1'b0);
    pkt_start(8'd2);
    tests++; if (wdata !== '0) begin fails++; $display("FAIL rst_pkt_clear got %0h exp 0", wdata); end
    put_bit(1'b1, 1'b0, 1'b0);
    put_bit(1'b0, 1'b0, 1'b1);
    tests++; if (wdata !== 'h1) begin fails++; $display("FAIL restart_wdata got %0h exp 1", wdata); end
    tests++; if (waddr !== '0) begin fails++; $display("FAIL restart_waddr got %0h exp 0", waddr); end
    tick();
    tests++; if (proc_done !== 1'b1) begin fails++; $display("FAIL restart_proc_done got %b exp 1", proc_done); end
    tests++; if (pulse_cnt !== 1) begin fails++; $display("FAIL restart_pulses got %0d exp 1", pulse_cnt); end
    tests++; if (o_err !== 1'b1) begin fails++; $display("FAIL restart_err got %b exp 1", o_err); end
    tick();
    tests++; if (mem[0] !== 'h1) begin fails++; $display("FAIL restart_row0 got %0h exp 1", mem[0]); end
  endtask

  task automatic test_en_drop();
    do_reset();
    start_job(6'd2);
    pkt_start(8'd4);
    put_bit(1'b1, 1'b0, 1'b0); put_bit(1'b0, 1'b0, 1'b0);
    put_bit(1'b1, 1'b0, 1'b0); put_bit(1'b0, 1'b0, 1'b1);
    tick();
    pkt_start(8'd200);
    put_bit(1'b1, 1'b0, 1'b0); put_bit(1'b1, 1'b0, 1'b0);
    tests++; if (waddr !== AW'(1)) begin fails++; $display("FAIL drop_waddr_pre got %0h exp 1", waddr); end
    tests++; if (o_err !== 1'b1) begin fails++; $display("FAIL drop_clamp_err got %b exp 1", o_err); end
    module_en = 1'b0;
    tick(); tick();
    i_pkt_start = 1'b1; i_k = 8'd4;
    tick();
    i_pkt_start = 1'b0;
    tests++; if (waddr !== AW'(1)) begin fails++; $display("FAIL drop_waddr_hold got %0h exp 1", waddr); end
    tests++; if (wdata !== 'h3) begin fails++; $display("FAIL drop_wdata_hold got %0h exp 3", wdata); end
    tests++; if (mem[0] !== 'h5) begin fails++; $display("FAIL drop_row0 got %0h exp 5", mem[0]); end
    tests++; if (o_err !== 1'b1) begin fails++; $display("FAIL drop_err_sticky got %b exp 1", o_err); end
    start_job(6'd1);
    tests++; if (o_err !== 1'b0) begin fails++; $display("FAIL drop_err_clear got %b exp 0", o_err); end
    pkt_start(8'd2);
    put_bit(1'b0, 1'b0, 1'b0);
    put_bit(1'b1, 1'b0, 1'b1);
    tests++; if ({waddr, wdata} !== {AW'(0), W'('h2)}) begin
      fails++; $display("FAIL drop_new_word got %0h/%0h exp 0/2", waddr, wdata);
    end
    tick();
    tests++; if ({proc_done, o_err} !== 2'b10) begin
      fails++; $display("FAIL drop_new_done got %b exp 10", {proc_done, o_err});
    end
  endtask

  task automatic test_zero_pkt();
    do_reset();
    start_job(6'd0);
    tests++; if (proc_done !== 1'b0) begin fails++; $display("FAIL zero_proc_c1 got %b exp 0", proc_done); end
    tick();
    tests++; if (proc_done !== 1'b1) begin fails++; $display("FAIL zero_proc_c2 got %b exp 1", proc_done); end
    pkt_start(8'd5);
    put_bit(1'b1, 1'b0, 1'b1);
    tick();
    tests++; if (pulse_cnt !== 0) begin fails++; $display("FAIL zero_pulses got %0d exp 0", pulse_cnt); end
    tests++; if (wdata !== '0) begin fails++; $display("FAIL zero_wdata got %0h exp 0", wdata); end
    tests++; if (proc_done !== 1'b1) begin fails++; $display("FAIL zero_proc_hold got %b exp 1", proc_done); end
  endtask

  initial begin
    ones = '1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_overflow();
    test_restart();
    test_en_drop();
    test_zero_pkt();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
